// File: rtl/zegar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zegar_pkg
// Description : Shared types and limits for the 24-hour BCD clock: the BCD
//               digit type, the display scan code and the hour/minute/second
//               maxima split into tens and units digits.
// Revision    : 1.0 - initial release
// ============================================================================
package zegar_pkg;

    // One BCD digit
    typedef logic [3:0] bcd_t;

    // Digit-select code driven to the display multiplexer
    typedef enum logic [1:0] {
        SCAN_HR2  = 2'b00,
        SCAN_HR1  = 2'b01,
        SCAN_MIN2 = 2'b10,
        SCAN_MIN1 = 2'b11
    } scan_t;

    // Counting limits (inclusive maxima)
    localparam int c_hour_max   = 23;
    localparam int c_minute_max = 59;
    localparam int c_second_max = 59;

    // The same limits split into tens / units digits for the BCD counters
    localparam bcd_t c_hour_tens_max  = bcd_t'(c_hour_max / 10);
    localparam bcd_t c_hour_units_max = bcd_t'(c_hour_max % 10);
    localparam bcd_t c_min_tens_max   = bcd_t'(c_minute_max / 10);
    localparam bcd_t c_min_units_max  = bcd_t'(c_minute_max % 10);
    localparam bcd_t c_sec_tens_max   = bcd_t'(c_second_max / 10);
    localparam bcd_t c_sec_units_max  = bcd_t'(c_second_max % 10);

    // Largest value a units digit may ever take
    localparam bcd_t c_bcd_max = 4'd9;

endpackage : zegar_pkg
`default_nettype wire

// File: rtl/zegar_licznik_if.sv
`default_nettype none
// ============================================================================
// Module      : zegar_licznik_if
// Description : Control and display bundle of the 24-hour clock: run enable,
//               the two set buttons, the four time digits, scan code, second
//               tick and colon blink.
// Revision    : 1.0 - initial release
// ============================================================================
interface zegar_licznik_if;
    import zegar_pkg::*;

    // Controls (toward the clock)
    logic       en_i;
    logic       inc_min_i;
    logic       inc_hr_i;

    // Display side (from the clock)
    bcd_t       hr2_o;
    bcd_t       hr1_o;
    bcd_t       min2_o;
    bcd_t       min1_o;
    logic [1:0] odswiezanie_o;
    logic       tick_o;
    logic       kropka_o;

    // Side that drives the controls and watches the display
    modport master (
        output en_i,
        output inc_min_i,
        output inc_hr_i,
        input  hr2_o,
        input  hr1_o,
        input  min2_o,
        input  min1_o,
        input  odswiezanie_o,
        input  tick_o,
        input  kropka_o
    );

    // The clock itself
    modport slave (
        input  en_i,
        input  inc_min_i,
        input  inc_hr_i,
        output hr2_o,
        output hr1_o,
        output min2_o,
        output min1_o,
        output odswiezanie_o,
        output tick_o,
        output kropka_o
    );

endinterface : zegar_licznik_if
`default_nettype wire

// File: rtl/licznik_bcd.sv
`default_nettype none
// ============================================================================
// Module      : licznik_bcd
// Description : Two-digit BCD counter that wraps after TENS_MAX:TOP_UNITS_MAX.
//               It can advance by 0, 1 or 2 in one cycle (2 lets the hour
//               counter absorb a set request and a minute carry together).
//               clear_i wins over inc_i and suppresses the carry.
// Revision    : 1.0 - initial release
// ============================================================================
module licznik_bcd
    import zegar_pkg::*;
#(
    parameter bcd_t TENS_MAX      = 4'd5,
    parameter bcd_t TOP_UNITS_MAX = 4'd9
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] inc_i,
    input  logic       clear_i,
    output bcd_t       tens_o,
    output bcd_t       units_o,
    output logic       carry_o
);

    bcd_t       r_tens;
    bcd_t       r_units;
    bcd_t       w_next_tens;
    bcd_t       w_next_units;
    logic       w_carry;
    logic [8:0] w_step1;
    logic [8:0] w_step2;

    // Advance a two-digit BCD value by one; bit 8 flags the wrap to 00
    function automatic logic [8:0] bcd_step(input bcd_t t, input bcd_t u);
        logic [8:0] res;
        if ((t == TENS_MAX) && (u == TOP_UNITS_MAX)) begin
            res = {1'b1, 8'h00};
        end else if (u >= c_bcd_max) begin
            res = {1'b0, t + 4'd1, 4'd0};
        end else begin
            res = {1'b0, t, u + 4'd1};
        end
        return res;
    endfunction

    assign w_step1 = bcd_step(r_tens, r_units);
    assign w_step2 = bcd_step(w_step1[7:4], w_step1[3:0]);

    // Select the next value and carry for the requested step size
    always_comb begin
        w_next_tens  = r_tens;
        w_next_units = r_units;
        w_carry      = 1'b0;
        if (clear_i) begin
            w_next_tens  = 4'd0;
            w_next_units = 4'd0;
        end else begin
            case (inc_i)
                2'd1: begin
                    w_next_tens  = w_step1[7:4];
                    w_next_units = w_step1[3:0];
                    w_carry      = w_step1[8];
                end
                2'd2, 2'd3: begin
                    w_next_tens  = w_step2[7:4];
                    w_next_units = w_step2[3:0];
                    w_carry      = w_step1[8] | w_step2[8];
                end
                default: begin
                    w_next_tens  = r_tens;
                    w_next_units = r_units;
                end
            endcase
        end
    end

    // Digit registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tens  <= 4'd0;
            r_units <= 4'd0;
        end else begin
            r_tens  <= w_next_tens;
            r_units <= w_next_units;
        end
    end

    assign tens_o  = r_tens;
    assign units_o = r_units;
    assign carry_o = w_carry;

endmodule : licznik_bcd
`default_nettype wire

// File: rtl/zegar_licznik.sv
`default_nettype none
// ============================================================================
// Module      : zegar_licznik
// Description : 24-hour HH:MM clock with hidden seconds. A prescaler turns
//               CLK_HZ cycles into one-second ticks; minute and hour set
//               buttons are rising-edge detected. A free-running refresh
//               counter supplies the display digit-select code.
// Revision    : 1.0 - initial release
// ============================================================================
module zegar_licznik
    import zegar_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SCAN_BITS = 19
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    zegar_licznik_if.slave    bus
);

    localparam int PRESC_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] c_presc_last = PRESC_W'(CLK_HZ - 1);

    logic [PRESC_W-1:0]   r_presc;
    logic [SCAN_BITS-1:0] r_scan;
    logic                 r_min_prev;
    logic                 r_hr_prev;
    logic                 r_tick;
    logic                 r_kropka;

    logic       w_min_edge;
    logic       w_hr_edge;
    logic       w_wrap;
    logic       w_tick;
    logic       w_sec_carry;
    logic       w_min_carry;
    logic       w_hr_from_min;
    logic [1:0] w_hr_step;
    logic       w_hr_carry_unused;
    bcd_t       w_sec_tens_unused;
    bcd_t       w_sec_units_unused;
    bcd_t       w_min_tens;
    bcd_t       w_min_units;
    bcd_t       w_hr_tens;
    bcd_t       w_hr_units;
    scan_t      w_scan;

    // Set buttons fire once per press; the previous-value registers
    // come out of reset high so a button held through reset is ignored.
    assign w_min_edge = bus.inc_min_i & ~r_min_prev;
    assign w_hr_edge  = bus.inc_hr_i  & ~r_hr_prev;

    // A minute-set press restarts the second, so a tick landing on it is lost
    assign w_wrap = bus.en_i & (r_presc == c_presc_last);
    assign w_tick = w_wrap & ~w_min_edge;

    // Setting minutes never ripples into hours; only a tick-driven carry does
    assign w_hr_from_min = w_min_carry & ~w_min_edge;
    assign w_hr_step     = {1'b0, w_hr_edge} + {1'b0, w_hr_from_min};

    // Button history for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_min_prev <= 1'b1;
            r_hr_prev  <= 1'b1;
        end else begin
            r_min_prev <= bus.inc_min_i;
            r_hr_prev  <= bus.inc_hr_i;
        end
    end

    // One-second prescaler: holds while disabled, restarts on a minute set
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_presc <= '0;
        end else if (w_min_edge) begin
            r_presc <= '0;
        end else if (bus.en_i) begin
            if (w_wrap) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PRESC_W'(1);
            end
        end
    end

    // Tick pulse and colon blink, aligned with the digit update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tick   <= 1'b0;
            r_kropka <= 1'b0;
        end else begin
            r_tick <= w_tick;
            if (w_tick) begin
                r_kropka <= ~r_kropka;
            end
        end
    end

    // Display refresh counter runs regardless of the enable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scan <= '0;
        end else begin
            r_scan <= r_scan + SCAN_BITS'(1);
        end
    end

    // Seconds are internal only; their digits are not shown
    licznik_bcd #(
        .TENS_MAX      (c_sec_tens_max),
        .TOP_UNITS_MAX (c_sec_units_max)
    ) u_sec (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   ({1'b0, w_tick}),
        .clear_i (w_min_edge),
        .tens_o  (w_sec_tens_unused),
        .units_o (w_sec_units_unused),
        .carry_o (w_sec_carry)
    );

    licznik_bcd #(
        .TENS_MAX      (c_min_tens_max),
        .TOP_UNITS_MAX (c_min_units_max)
    ) u_min (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   ({1'b0, w_min_edge | w_sec_carry}),
        .clear_i (1'b0),
        .tens_o  (w_min_tens),
        .units_o (w_min_units),
        .carry_o (w_min_carry)
    );

    // Midnight wrap of hours has no further consumer
    licznik_bcd #(
        .TENS_MAX      (c_hour_tens_max),
        .TOP_UNITS_MAX (c_hour_units_max)
    ) u_hr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (w_hr_step),
        .clear_i (1'b0),
        .tens_o  (w_hr_tens),
        .units_o (w_hr_units),
        .carry_o (w_hr_carry_unused)
    );

    assign w_scan = scan_t'(r_scan[SCAN_BITS-1 -: 2]);

    assign bus.hr2_o         = w_hr_tens;
    assign bus.hr1_o         = w_hr_units;
    assign bus.min2_o        = w_min_tens;
    assign bus.min1_o        = w_min_units;
    assign bus.odswiezanie_o = w_scan;
    assign bus.tick_o        = r_tick;
    assign bus.kropka_o      = r_kropka;

endmodule : zegar_licznik
`default_nettype wire
